// File: rtl/red_accum_seq.sv
// Multi-cycle RED reduction: sums LANES lane pairs of a and b (one pair per cycle) into a signed
// accumulator. Optional clamping of the result is enabled by defining RED_SATURATE_EN.
module red_accum_seq #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int RES_W  = 7,
    parameter int OUT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   a,
    input  logic [LANES*LANE_W-1:0]   b,
    input  logic                      signed_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          result,
    output logic                      sat
);

    localparam int ACC_W = LANE_W + 2 + $clog2(LANES);
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [LANES*LANE_W-1:0] a_p0, b_p0;
    logic                    signed_p0;
    logic [IDX_W-1:0]        idx_p1;
    logic signed [ACC_W-1:0] acc_p1;
    logic signed [ACC_W-1:0] sum_p1;
    logic [LANE_W-1:0]       a_lane, b_lane;
    logic [OUT_W-1:0]        result_p2;
    logic                    load, last;

    function automatic logic signed [ACC_W-1:0] ext(input logic [LANE_W-1:0] v,
                                                    input logic sm);
        if (sm)
            return {{(ACC_W-LANE_W){v[LANE_W-1]}}, v};
        else
            return {{(ACC_W-LANE_W){1'b0}}, v};
    endfunction

    function automatic logic [OUT_W-1:0] sext_res(input logic signed [RES_W-1:0] v);
        return OUT_W'(v);
    endfunction

`ifdef RED_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (RES_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (RES_W-1)));

    // Returns {clamped, value}; value is the clamped accumulator sign-extended to OUT_W.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return {1'b1, sext_res(SAT_MAX[RES_W-1:0])};
        else if (v < SAT_MIN)
            return {1'b1, sext_res(SAT_MIN[RES_W-1:0])};
        else
            return {1'b0, sext_res(v[RES_W-1:0])};
    endfunction

    logic       sat_p2;
    logic [OUT_W:0] fin;
    always_comb fin = saturate(sum_p1);
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign load      = (state == IDLE) && in_valid;
    assign last      = (state == ACCUM) && (idx_p1 == IDX_W'(LANES-1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = ACCUM;
            ACCUM:   if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: operand capture on accept; later input changes have no effect
    always_ff @(posedge clk) begin
        if (load) begin
            a_p0      <= a;
            b_p0      <= b;
            signed_p0 <= signed_mode;
        end
    end

    // Stage p1: one lane pair folded into the accumulator per cycle
    always_comb begin
        a_lane = a_p0[idx_p1*LANE_W +: LANE_W];
        b_lane = b_p0[idx_p1*LANE_W +: LANE_W];
        sum_p1 = acc_p1 + ext(a_lane, signed_p0) + ext(b_lane, signed_p0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_p1    <= '0;
            idx_p1    <= '0;
            result_p2 <= '0;
`ifdef RED_SATURATE_EN
            sat_p2    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (load) begin
                acc_p1 <= '0;
                idx_p1 <= '0;
            end else if (state == ACCUM) begin
                acc_p1 <= sum_p1;
                idx_p1 <= idx_p1 + IDX_W'(1);
            end
            // Stage p2: result captured from the final sum and held through DONE
            if (last) begin
`ifdef RED_SATURATE_EN
                result_p2 <= fin[OUT_W-1:0];
                sat_p2    <= fin[OUT_W];
`else
                result_p2 <= sext_res(sum_p1[RES_W-1:0]);
`endif
            end
        end
    end

    assign result = result_p2;
`ifdef RED_SATURATE_EN
    assign sat = sat_p2;
`else
    assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_red_accum_seq.sv
// Scoreboard bench for red_accum_seq: directed operations push expected results, a monitor
// pops and compares them at each output handshake.
module tb_red_accum_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        sat;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    red_accum_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a result is consumed on the edge following a negedge with valid && ready
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {15'd0, sat, result}, 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("result", {16'd0, result}, {16'd0, e[15:0]});
                check("sat", {31'd0, sat}, {31'd0, e[16]});
            end
        end
    end

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                            input logic push, input logic [15:0] eres, input logic esat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        a           = av;
        b           = bv;
        signed_mode = sm;
        if (push) exp_q.push_back({esat, eres});
        tick();
        in_valid    = 1'b0;
        a           = 16'h5A5A;
        b           = 16'hA5A5;
        signed_mode = ~sm;
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_valid();
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            tick();
            lat++;
        end
        check("latency", lat, 32'd4);
    endtask

    task automatic finish_op();
        tick();
        check("out_valid_released", {31'd0, out_valid}, 32'd0);
        check("in_ready_released", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] ovf_res;
        logic        ovf_sat;
`ifdef RED_SATURATE_EN
        ovf_res = 16'h003F;
        ovf_sat = 1'b1;
`else
        ovf_res = 16'hFFF8;
        ovf_sat = 1'b0;
`endif
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;

        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", {16'd0, result}, 32'h0000);
        check("reset_sat", {31'd0, sat}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Unsigned sum 14
        start_op(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h000E, 1'b0);
        wait_valid();
        finish_op();

        // Unsigned overflow, sum 120
        start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, ovf_res, ovf_sat);
        wait_valid();
        finish_op();

        // Signed sum -36
        start_op(16'hFFFF, 16'h8888, 1'b1, 1'b1, 16'hFFDC, 1'b0);
        wait_valid();
        finish_op();

        // Backpressure with new operands offered throughout the stall
        out_ready = 1'b0;
        start_op(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h000E, 1'b0);
        wait_valid();
        in_valid    = 1'b1;
        a           = 16'hFFFF;
        b           = 16'h8888;
        signed_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_result", {16'd0, result}, 32'h000E);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({1'b0, 16'hFFDC});
        tick();
        in_valid = 1'b0;
        check("second_accept", {31'd0, in_ready}, 32'd0);
        wait_valid();
        finish_op();

        // Reset on the second ACCUM edge discards the operation
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midreset_no_valid", {31'd0, out_valid}, 32'd0);
        end
        start_op(16'hFFFF, 16'h8888, 1'b1, 1'b1, 16'hFFDC, 1'b0);
        wait_valid();
        finish_op();

        tick();
        tick();
        check("pending_results", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
